ipr_bulk_writer: RTL and testbench

Single-clock initiator for the write side of an IPR endpoint. Accepts a transfer command (word count), pulls words from a local valid/ready source stream, and pushes each word into the IPR write port using its req/gnt/rvalid handshake. It is the producer-core master that feeds an IPR FIFO. It enforces the one-outstanding-access rule of the IPR slave and aborts on a grant timeout when the FIFO stays full.

---
 rtl/ipr_bulk_writer.sv | 169 ++++++++++++++++
 tb/tb_ipr_bulk_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipr_bulk_writer.sv
// ipr_bulk_writer: takes a word-count command, pulls words from a
// valid/ready source and writes them one at a time into an IPR write port.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_len  transfer command (word count)
//   src_valid/src_ready/src_data source word stream
//   ipr_req/we/addr/wdata        IPR write request side
//   ipr_gnt/ipr_rvalid           IPR grant and response
//   busy, done, timeout_err      status; done/timeout_err are pulses
//   proto_err                    sticky, rvalid seen outside WAIT
//   words_sent                   words acknowledged this/last transfer
module ipr_bulk_writer #(
  parameter int          DATA_W        = 32,
  parameter int          LEN_W         = 16,
  parameter logic [31:0] IPR_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_LIMIT = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  output logic              ipr_req,
  output logic              ipr_we,
  output logic [31:0]       ipr_addr,
  output logic [DATA_W-1:0] ipr_wdata,
  input  logic              ipr_gnt,
  input  logic              ipr_rvalid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [LEN_W-1:0]  words_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT
  } state_e;

  localparam int TW =
    (TIMEOUT_LIMIT > 1) ? $clog2(TIMEOUT_LIMIT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_LIMIT);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              perr_q, perr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sent_q  <= '0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sent_q  <= sent_d;
      wdata_q <= wdata_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sent_d  = sent_q;
    wdata_d = wdata_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    // Responses are only legal while waiting for one.
    perr_d  = perr_q |
              (ipr_rvalid && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rem_d  = cmd_len;
          sent_d = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        tcnt_d = '0;
        if (src_valid) begin
          wdata_d = src_data;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // A grant on the threshold cycle still wins.
        if (ipr_gnt) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end else if (TIMEOUT_LIMIT != 0) begin
          if (tcnt_q == TLIM - TW'(1)) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
            tcnt_d  = '0;
            wdata_d = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      S_WAIT: begin
        if (ipr_rvalid) begin
          sent_d = sent_q + LEN_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered request: falls on the edge that samples the grant,
    // so the slave sees exactly one granted req&&we cycle per word.
    req_d = (state_d == S_REQ);
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign src_ready   = (state_q == S_FETCH);
  assign busy        = (state_q != S_IDLE);
  assign ipr_req     = req_q;
  assign ipr_we      = req_q;
  assign ipr_addr    = IPR_ADDR;
  assign ipr_wdata   = wdata_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign proto_err   = perr_q;
  assign words_sent  = sent_q;

endmodule

// File: tb/tb_ipr_bulk_writer.sv
// tb_ipr_bulk_writer: vector table of transfers with an IPR slave model
// and a source-word scoreboard, plus protocol-error and reset sequences.
module tb_ipr_bulk_writer;

  localparam int NEVER = 100000;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic        ipr_req;
  logic        ipr_we;
  logic [31:0] ipr_addr;
  logic [31:0] ipr_wdata;
  logic        ipr_gnt;
  logic        ipr_rvalid;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        proto_err;
  logic [15:0] words_sent;

  ipr_bulk_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .ipr_req    (ipr_req),
    .ipr_we     (ipr_we),
    .ipr_addr   (ipr_addr),
    .ipr_wdata  (ipr_wdata),
    .ipr_gnt    (ipr_gnt),
    .ipr_rvalid (ipr_rvalid),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .proto_err  (proto_err),
    .words_sent (words_sent)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int len;
    int gdly;
    int abort_at;
    int exp_req;
    int exp_end;
    bit exp_tmo;
    int exp_words;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_req", ipr_req, 0);
    chk("rst_we", ipr_we, 0);
    chk("rst_wdata", ipr_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_perr", proto_err, 0);
    chk("rst_sent", words_sent, 0);
    chk("rst_addr", ipr_addr, 0);
  endtask

  task automatic run_xfer(input vec_t v, input logic [31:0] base);
    int cyc, reqc, ng, gw, k, endc;
    bit gnt_prev, req_prev, got_tmo, src_seen, hs;
    logic [31:0] hold, exp_w;
    reqc = 0; ng = 0; gw = 0; k = 0; endc = -1;
    gnt_prev = 0; req_prev = 0; got_tmo = 0;
    src_seen = 0; hold = '0;
    chk("start_cmd_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_len = v.len[15:0];
    src_valid = 1;
    src_data = base;
    @(posedge clk); #1;
    cmd_valid = 0;
    cyc = 1;
    while (cyc < 600) begin
      if (v.abort_at != 0 && cyc == v.abort_at) begin
        chk("pre_abort_busy", busy, 1);
        chk("pre_abort_req", ipr_req, 0);
        chk("pre_abort_srdy", src_ready, 0);
        chk("pre_abort_sent", words_sent, v.exp_words);
        ipr_gnt = 0;
        ipr_rvalid = 0;
        #2 rst_n = 0;
        #1 chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;
        src_valid = 0;
        sb.delete();
        return;
      end
      if (done || timeout_err) begin
        endc = cyc;
        got_tmo = timeout_err;
        break;
      end
      ipr_rvalid = gnt_prev;
      ipr_gnt = 0;
      hs = src_ready;
      if (hs) begin
        src_seen = 1;
        sb.push_back(src_data);
      end
      if (ipr_req) begin
        if (req_prev) chk("wdata_stable", ipr_wdata, hold);
        hold = ipr_wdata;
        reqc++;
        if (ng == 0 && gw < v.gdly) begin
          gw++;
        end else begin
          ipr_gnt = 1;
          ng++;
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            exp_w = sb.pop_front();
            chk("wdata", ipr_wdata, exp_w);
          end
        end
      end
      gnt_prev = ipr_gnt && ipr_req;
      req_prev = ipr_req;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        src_data = base + k;
      end
      cyc++;
    end
    ipr_gnt = 0;
    ipr_rvalid = 0;
    src_valid = 0;
    chk("end_cycle", endc, v.exp_end);
    chk("tmo_seen", got_tmo, v.exp_tmo);
    chk("done_at_end", done, !v.exp_tmo);
    chk("req_cycles", reqc, v.exp_req);
    chk("words_sent", words_sent, v.exp_words);
    chk("end_req", ipr_req, 0);
    chk("end_busy", busy, 0);
    chk("sb_left", sb.size(), v.exp_tmo ? 1 : 0);
    if (v.len == 0) chk("len0_src", src_seen, 0);
    sb.delete();
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("tmo_pulse", timeout_err, 0);
    chk("sent_hold", words_sent, v.exp_words);
  endtask

  vec_t tbl[6];
  vec_t vp, va;

  initial begin
    rst_n = 0;
    cmd_valid = 0;
    cmd_len = '0;
    src_valid = 0;
    src_data = '0;
    ipr_gnt = 0;
    ipr_rvalid = 0;

    tbl[0] = '{4, 0,     0, 4,   13,  1'b0, 4};
    tbl[1] = '{2, 5,     0, 7,   12,  1'b0, 2};
    tbl[2] = '{3, NEVER, 0, 100, 102, 1'b1, 0};
    tbl[3] = '{0, 0,     0, 0,   1,   1'b0, 0};
    tbl[4] = '{3, 2,     0, 5,   12,  1'b0, 3};
    tbl[5] = '{1, 99,    0, 100, 103, 1'b0, 1};
    vp     = '{1, 0,     0, 1,   4,   1'b0, 1};
    va     = '{5, 0,     6, 0,   0,   1'b0, 1};

    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk_reset_vals();

    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i], 32'hA0 + 32'(i * 16));
    end

    ipr_rvalid = 1;
    @(posedge clk); #1;
    ipr_rvalid = 0;
    chk("perr_set", proto_err, 1);
    run_xfer(vp, 32'h5A00);
    chk("perr_sticky", proto_err, 1);
    #2 rst_n = 0;
    #1 chk("perr_rst", proto_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    run_xfer(va, 32'hB000);
    @(posedge clk); #1;
    run_xfer(vp, 32'hC000);
    chk("perr_clear", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
